sram_burst_master: RTL and testbench
====================================

// Module: sram_burst_master
// PURPOSE
// - Initiator side of the single-port sRAM interface (en/rd/wt/add/din/dout, 1-cycle registered read).
// - Accepts single or burst commands from the processor datapath over a valid/ready handshake.
// - Sequences the sRAM control pins and streams read data back one word per cycle.
// - Supports constant-fill write bursts for memory clear/init.
// PARAMETERS
// - AW  8  address width; addresses wrap mod 2**AW
// - DW  8  data width
// - LW  4  burst-length field width; beats = cmd_len+1, range 1..2**LW
// PORTS
// - clk        in   1   single clock, all state updates on posedge
// - rst        in   1   synchronous reset, active-high
// - cmd_valid  in   1   command offered
// - cmd_ready  out  1   high only in IDLE; accept = cmd_valid&&cmd_ready at posedge
// - cmd_wr     in   1   1=write (fill) burst, 0=read burst
// - cmd_addr   in   AW  base address
// - cmd_len    in   LW  beats-1
// - cmd_wdata  in   DW  fill value written on every write beat
// - rsp_valid  out  1   rsp_data holds one read word this cycle (no backpressure)
// - rsp_data   out  DW  read word, registered
// - done       out  1   one-cycle pulse at command completion
// - busy       out  1   ~cmd_ready
// - mem_en     out  1   to sRAM en
// - mem_rd     out  1   to sRAM rd
// - mem_wt     out  1   to sRAM wt
// - mem_add    out  AW  to sRAM add
// - mem_din    out  DW  to sRAM din
// - mem_dout   in   DW  from sRAM dout, valid the cycle after a read issue
// BEHAVIOUR
// - Reset (clk edge with rst=1): state IDLE; mem_en/rd/wt=0, mem_add=0, mem_din=0, rsp_valid=0,
//   rsp_data=0, done=0, cmd_ready=1 after release. Reset mid-burst aborts: no further beats, rsp or done.
// - FSM: IDLE -> WRITE (cmd_wr=1) | READ (cmd_wr=0); WRITE -> IDLE after last beat;
//   READ -> FLUSH after last beat; FLUSH lasts exactly 2 cycles -> IDLE.
// - Accept at edge E; beat i (0-based) driven during cycle E+1+i: mem_en=1, mem_add=(cmd_addr+i) mod 2**AW.
// - WRITE beat: mem_wt=1, mem_rd=0, mem_din=latched cmd_wdata.
// - READ beat: mem_rd=1, mem_wt=0; mem_dout valid in cycle E+2+i; captured into rsp_data at end of that
//   cycle; rsp_valid=1 during cycle E+3+i. L beats give L consecutive rsp_valid cycles, no gaps.
// - mem_rd and mem_wt never both 1; mem_en=0 and mem_rd=mem_wt=0 in IDLE and FLUSH.
// - done: write -> cycle E+1+L (first IDLE cycle); read -> cycle E+2+L (coincides with last rsp_valid).
// - cmd_ready=0 in WRITE/READ/FLUSH; commands offered then are not accepted and not lost by requester.
// - Command fields latched at accept; changes on cmd_* while busy have no effect.
// - Beat counter LW+1 bits wide; cmd_len=all-ones gives 2**LW beats; address wraps silently (0xFF->0x00).
// - Back-to-back: new command may be accepted in the same IDLE cycle that a write done pulses.
// STRUCTURE
// - Package sram_master_pkg: state enum {IDLE,WRITE,READ,FLUSH}, AW/DW/LW defaults, beat-count function.
// - One sub-module sram_addr_gen: loads base/len on accept, increments address mod 2**AW each beat,
//   flags last beat. Top holds FSM, read-valid shift pipeline (2 stages) and rsp_data register.
// - Bench pairs this block with the existing 8-bit sRAM model (en/rd/wt/add/din/dout).
// TESTING
// - Reset: hold rst 3 cycles mid-operation -> all outputs 0, cmd_ready=1 next cycle, no done.
// - Single write addr 0x03 data 0xA5 then single read 0x03 -> rsp_valid once at E+3, rsp_data=0xA5, done same cycle.
// - Fill: addr 0xFE len 3 data 0x5A -> mem_add 0xFE,0xFF,0x00,0x01 with mem_wt=1; readback all 0x5A.
// - Read burst 4 from 0x00 after writing 0x10..0x13 -> rsp 0x10,0x11,0x12,0x13 on 4 consecutive cycles.
// - cmd_valid held high while busy with different addr -> ignored; accepted in first IDLE cycle after done.
// - Reset asserted on beat 2 of 8-beat fill at 0x20 -> 0x20,0x21 written only; 0x22 unchanged; no done.

Source files
------------

// File: rtl/sram_master_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_master_pkg
// Brief  : Shared widths, FSM state encoding and beat-count helper for the
//          sRAM burst master.
// Rev    : 1.0  initial release
// ============================================================================
package sram_master_pkg;

    localparam int unsigned c_AW = 8;
    localparam int unsigned c_DW = 8;
    localparam int unsigned c_LW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Length field encodes beats-1, so all-ones yields the full 2**LW beats.
    function automatic int unsigned beat_count(input int unsigned len);
        return len + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : sram_addr_gen
// Brief  : Burst address walker; loads base/length on accept, advances one
//          word per beat (wrapping mod 2**AW) and flags the final beat.
// Rev    : 1.0  initial release
// ============================================================================
module sram_addr_gen
    import sram_master_pkg::*;
#(
    parameter int unsigned AW = c_AW,
    parameter int unsigned LW = c_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int unsigned c_CW = LW + 1;

    logic [AW-1:0]   r_addr;
    logic [c_CW-1:0] r_remain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (load) begin
            r_addr   <= base;
            r_remain <= c_CW'(beat_count(32'(len)));
        end else if (step) begin
            r_addr   <= r_addr + AW'(1);
            r_remain <= r_remain - c_CW'(1);
        end
    end

    assign addr = r_addr;
    assign last = (r_remain == c_CW'(1));

endmodule
`default_nettype wire

// File: rtl/sram_burst_master.sv
`default_nettype none
// ============================================================================
// Module : sram_burst_master
// Brief  : Initiator for a single-port sRAM with 1-cycle registered read;
//          sequences single/burst fill-writes and reads, streams read data.
// Rev    : 1.0  initial release
// ============================================================================
module sram_burst_master
    import sram_master_pkg::*;
#(
    parameter int unsigned AW = c_AW,
    parameter int unsigned DW = c_DW,
    parameter int unsigned LW = c_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          done,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_rd,
    output logic          mem_wt,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_flush;
    logic [DW-1:0] r_wdata;
    logic [1:0]    r_rd_pipe;
    logic [DW-1:0] r_rsp_data;
    logic          r_done;

    logic          w_accept;
    logic          w_step;
    logic          w_last;
    logic          w_done_nxt;
    logic [AW-1:0] w_addr;

    sram_addr_gen #(
        .AW (AW),
        .LW (LW)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (w_accept),
        .step (w_step),
        .base (cmd_addr),
        .len  (cmd_len),
        .addr (w_addr),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= (r_state == ST_FLUSH) ? ~r_flush : 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        mem_en      = 1'b0;
        mem_rd      = 1'b0;
        mem_wt      = 1'b0;
        mem_add     = '0;
        mem_din     = '0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = cmd_wr ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                mem_en  = 1'b1;
                mem_wt  = 1'b1;
                mem_add = w_addr;
                mem_din = r_wdata;
                w_step  = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_READ: begin
                mem_en  = 1'b1;
                mem_rd  = 1'b1;
                mem_add = w_addr;
                w_step  = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Two drain cycles; done lands with the final read response.
                if (r_flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read issue -> sRAM output stage -> captured response stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdata    <= '0;
            r_rd_pipe  <= '0;
            r_rsp_data <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wdata <= cmd_wdata;
            end
            r_rd_pipe <= {r_rd_pipe[0], mem_rd};
            if (r_rd_pipe[0]) begin
                r_rsp_data <= mem_dout;
            end
            r_done <= w_done_nxt;
        end
    end

    assign busy      = ~cmd_ready;
    assign rsp_valid = r_rd_pipe[1];
    assign rsp_data  = r_rsp_data;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_master.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_burst_master
// Brief  : Self-checking bench for sram_burst_master with an 8-bit sRAM model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sram_burst_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [3:0] cmd_len = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       done;
    logic       busy;
    logic       mem_en;
    logic       mem_rd;
    logic       mem_wt;
    logic [7:0] mem_add;
    logic [7:0] mem_din;
    logic [7:0] mem_dout = '0;

    logic [7:0] sram    [256];
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_burst_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .done      (done),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_rd    (mem_rd),
        .mem_wt    (mem_wt),
        .mem_add   (mem_add),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Single-port sRAM: write on wt, registered read on rd.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wt) sram[mem_add] <= mem_din;
            if (mem_rd) mem_dout <= sram[mem_add];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; checks every cycle until the master is idle again.
    task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                           input logic [7:0] data);
        int          nb;
        int          last_k;
        logic        e_rdy, e_en, e_rd, e_wt, e_v, e_dn;
        logic [7:0]  e_add, e_din, e_dat;
        logic [63:0] obs, exp;
        nb     = int'(len) + 1;
        last_k = wr ? nb + 1 : nb + 3;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_wdata = data;
        chk("accept_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            e_en  = (k <= nb);
            e_wt  = wr && e_en;
            e_rd  = !wr && e_en;
            e_add = e_en ? 8'(int'(addr) + k - 1) : 8'h00;
            e_din = e_wt ? data : 8'h00;
            e_v   = !wr && (k >= 3) && (k <= nb + 2);
            e_dat = e_v ? ref_mem[8'(int'(addr) + k - 3)] : 8'h00;
            e_dn  = wr ? (k == nb + 1) : (k == nb + 2);
            e_rdy = wr ? (k >= nb + 1) : (k >= nb + 3);
            obs = 64'({cmd_ready, busy, mem_en, mem_rd, mem_wt, (e_en ? mem_add : 8'h00),
                       (e_wt ? mem_din : 8'h00), rsp_valid, (e_v ? rsp_data : 8'h00), done});
            exp = 64'({e_rdy, ~e_rdy, e_en, e_rd, e_wt, e_add, e_din, e_v, e_dat, e_dn});
            chk($sformatf("%s a=%02h l=%0d k=%0d", wr ? "wr" : "rd", addr, len, k), obs, exp);
            if (k < last_k) begin
                // Junk offered while busy must be ignored.
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_wr    = 1'($urandom_range(0, 1));
                cmd_addr  = 8'($urandom);
                cmd_len   = 4'($urandom);
                cmd_wdata = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        if (wr) begin
            for (int i = 0; i < nb; i++) ref_mem[8'(int'(addr) + i)] = data;
        end
    endtask

    // Called at a negedge; holds reset n cycles, then checks quiet idle after release.
    task automatic reset_hold(input int n);
        cmd_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("rst_zero c=%0d", i),
                64'({busy, mem_en, mem_rd, mem_wt, mem_add, mem_din, rsp_valid, rsp_data, done}),
                64'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst c=%0d", i),
                64'({cmd_ready, mem_en, rsp_valid, done}), 64'b1000);
        end
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            sram[i]    = v;
            ref_mem[i] = v;
        end
        sram[8'h22]    = 8'hC3;
        ref_mem[8'h22] = 8'hC3;

        // Power-on reset
        repeat (3) begin
            @(negedge clk);
            chk("init_rst", 64'({mem_en, mem_rd, mem_wt, mem_add, mem_din, rsp_valid, rsp_data, done}),
                64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("init_ready", 64'({cmd_ready, done}), 64'b10);

        // Single write then single read
        run_cmd(1'b1, 8'h03, 4'd0, 8'hA5);
        run_cmd(1'b0, 8'h03, 4'd0, 8'h00);

        // Wrapping fill and readback
        run_cmd(1'b1, 8'hFE, 4'd3, 8'h5A);
        run_cmd(1'b0, 8'hFE, 4'd3, 8'h00);

        // Distinct words then a 4-beat read
        for (int i = 0; i < 4; i++) run_cmd(1'b1, 8'(i), 4'd0, 8'(8'h10 + i));
        run_cmd(1'b0, 8'h00, 4'd3, 8'h00);

        // Full-length burst
        run_cmd(1'b1, 8'hF8, 4'hF, 8'h77);
        run_cmd(1'b0, 8'hF8, 4'hF, 8'h00);

        // Reset in the middle of an 8-beat read
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h40; cmd_len = 4'd7;
        @(posedge clk);
        repeat (3) @(negedge clk);
        reset_hold(3);

        // Reset arriving as the third beat of an 8-beat fill would start
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h20; cmd_len = 4'd7; cmd_wdata = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset_hold(1);
        ref_mem[8'h20] = 8'h3C;
        ref_mem[8'h21] = 8'h3C;
        run_cmd(1'b0, 8'h1F, 4'd3, 8'h00);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            run_cmd(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
